// File: rtl/data_memory_responder_if.sv
// Data memory port bundle between the pipeline (master) and the responder (slave).
// Latency: n/a (wires only).
// Backpressure: slave raises stall; master holds every request field stable while it is high.
interface data_memory_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [2:0]  funct3;
  logic [31:0] readData;
  logic        stall;
  logic        fault;
  logic [31:0] debugOut;

  modport master (
    output memRead, memWrite, address, writeData, funct3,
    input  readData, stall, fault, debugOut
  );

  modport slave (
    input  memRead, memWrite, address, writeData, funct3,
    output readData, stall, fault, debugOut
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: byte/half/word loads and stores on an internal RAM plus one MMIO debug word.
// Latency: LATENCY cycles of stall, then one DONE cycle with the result (LATENCY=0: fully combinational).
// Backpressure: stall holds the pipeline from request capture until DONE; a faulting access writes nothing.
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFFC
) (
  input  logic                          clk,
  input  logic                          reset,
  data_memory_responder_if.slave        bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // The latency counter is 4 bits wide.
  if (LATENCY < 0 || LATENCY > 15) begin : gLatencyCheck
    $error("data_memory_responder: LATENCY must be within 0..15");
  end

  // Fault rules: illegal size code, unsigned size on a store, misalignment,
  // non-word MMIO access, or a word index outside the RAM that is not MMIO.
  function automatic logic accessFault(input logic [31:0] a, input logic [2:0] f3,
                                       input logic isWrite);
    logic isMmio;
    logic bad;
    isMmio = (a == MMIO_ADDR);
    case (f3)
      3'b000:  bad = isMmio;
      3'b001:  bad = a[0] | isMmio;
      3'b010:  bad = (a[1:0] != 2'b00);
      3'b100:  bad = isWrite | isMmio;
      3'b101:  bad = isWrite | a[0] | isMmio;
      default: bad = 1'b1;
    endcase
    if (!isMmio && ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS))) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] storeMask(input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] storeData(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] debugReg;

  // "Effective" request: live inputs in combinational mode or while idle, captured copy otherwise.
  logic [31:0]   effAddr;
  logic [31:0]   effData;
  logic [2:0]    effFunct3;
  logic          effWrite;
  logic          effFault;
  logic          effMmio;
  logic [AW-1:0] effIdx;
  logic [31:0]   loadValue;
  logic          commit;
  logic [3:0]    wrMask;
  logic [31:0]   wrData;

  assign effMmio   = (effAddr == MMIO_ADDR);
  assign effIdx    = effAddr[AW+1:2];
  assign effFault  = accessFault(effAddr, effFunct3, effWrite);
  assign loadValue = effMmio ? debugReg : loadExtend(mem[effIdx], effAddr[1:0], effFunct3);
  assign wrMask    = storeMask(effAddr[1:0], effFunct3);
  assign wrData    = storeData(effData, effFunct3);
  assign bus.debugOut = debugReg;

  // RAM byte-lane write; an access aborted by reset never lands.
  always_ff @(posedge clk) begin
    if (commit && !effMmio && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask[i]) mem[effIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  // MMIO debug register, written only by a committed word store to MMIO_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debugReg <= '0;
    end else if (commit && effMmio) begin
      debugReg <= effData;
    end
  end

  if (LATENCY == 0) begin : gComb
    assign effAddr   = bus.address;
    assign effData   = bus.writeData;
    assign effFunct3 = bus.funct3;
    assign effWrite  = bus.memWrite;
    assign commit    = bus.memWrite && !effFault;

    assign bus.stall    = 1'b0;
    assign bus.fault    = !reset && (bus.memRead || bus.memWrite) && effFault;
    assign bus.readData = (!reset && bus.memRead && !bus.memWrite && !effFault) ? loadValue : '0;
  end else begin : gSeq
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, stateNext;
    logic [3:0]  counter, counterNext;
    logic [31:0] capAddr;
    logic [31:0] capData;
    logic [2:0]  capFunct3;
    logic        capWrite;
    logic [31:0] loadReg;
    logic        req;
    logic        inIdle;

    assign req    = bus.memRead | bus.memWrite;
    assign inIdle = (state == IDLE);

    assign effAddr   = inIdle ? bus.address   : capAddr;
    assign effData   = inIdle ? bus.writeData : capData;
    assign effFunct3 = inIdle ? bus.funct3    : capFunct3;
    assign effWrite  = inIdle ? bus.memWrite  : capWrite;

    // Stores land on the edge leaving DONE, i.e. when the pipeline advances.
    assign commit = (state == DONE) && capWrite && !effFault;

    assign bus.stall    = !reset && ((inIdle && req) || (state == WAIT));
    assign bus.fault    = (state == DONE) && effFault;
    assign bus.readData = (state == DONE) ? loadReg : '0;

    // Next-state and latency counter.
    always_comb begin
      stateNext   = state;
      counterNext = counter;
      case (state)
        IDLE: begin
          if (req) begin
            counterNext = 4'(LATENCY - 1);
            stateNext   = (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          counterNext = counter - 4'd1;
          if (counter == 4'd1) stateNext = DONE;
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        counter <= '0;
      end else begin
        state   <= stateNext;
        counter <= counterNext;
      end
    end

    // Capture the request when it is accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        capAddr   <= '0;
        capData   <= '0;
        capFunct3 <= '0;
        capWrite  <= 1'b0;
      end else if (inIdle && req) begin
        capAddr   <= bus.address;
        capData   <= bus.writeData;
        capFunct3 <= bus.funct3;
        capWrite  <= bus.memWrite;
      end
    end

    // Register load data on the edge entering DONE; stores and faults return zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        loadReg <= '0;
      end else if (stateNext == DONE && state != DONE) begin
        loadReg <= (!effWrite && !effFault) ? loadValue : '0;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 instance plus a LATENCY=0 instance.
// Latency: checks stall length and DONE-only read data on the sequential build.
// Backpressure: inputs held stable while stall is high; every wait is cycle-bounded.
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  data_memory_responder_if b2 ();
  data_memory_responder_if b0 ();

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2), .MMIO_ADDR(32'hFFFF_FFFC)) u2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(0), .MMIO_ADDR(32'hFFFF_FFFC)) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive2(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3);
    b2.memRead = rd; b2.memWrite = wr; b2.address = a; b2.writeData = d; b2.funct3 = f3;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3);
    b0.memRead = rd; b0.memWrite = wr; b0.address = a; b0.writeData = d; b0.funct3 = f3;
  endtask

  // One full access on the LATENCY=2 instance: stall for two cycles, result in DONE, then idle.
  task automatic acc2(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3,
                      input logic [31:0] expRd, input logic expFault);
    int n;
    @(negedge clk);
    drive2(rd, wr, a, d, f3);
    #1;
    chk({tag, "_stall_first"}, 32'(b2.stall), 32'd1);
    chk({tag, "_rd_first"}, b2.readData, 32'h0);
    n = 1;
    @(negedge clk);
    while (b2.stall === 1'b1 && n < 20) begin
      chk({tag, "_rd_wait"}, b2.readData, 32'h0);
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd2);
    chk({tag, "_rd_done"}, b2.readData, expRd);
    chk({tag, "_fault_done"}, 32'(b2.fault), 32'(expFault));
    drive2(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    chk({tag, "_rd_after"}, b2.readData, 32'h0);
    chk({tag, "_fault_after"}, 32'(b2.fault), 32'd0);
  endtask

  initial begin
    drive2(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("rst_stall", 32'(b2.stall), 32'd0);
    chk("rst_rd", b2.readData, 32'h0);
    chk("rst_fault", 32'(b2.fault), 32'd0);
    chk("rst_dbg", b2.debugOut, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Word store then load.
    acc2("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    acc2("lw10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Byte and halfword lanes with extension.
    acc2("sw20", 1'b0, 1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);
    acc2("sb21", 1'b0, 1'b1, 32'h21, 32'h80, 3'b000, 32'h0, 1'b0);
    acc2("lb21", 1'b1, 1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    acc2("lbu21", 1'b1, 1'b0, 32'h21, 32'h0, 3'b100, 32'h00000080, 1'b0);
    acc2("lw20a", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h00008000, 1'b0);
    acc2("sh22", 1'b0, 1'b1, 32'h22, 32'h0000BEEF, 3'b001, 32'h0, 1'b0);
    acc2("lh22", 1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    acc2("lhu22", 1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);

    // Faults: misaligned, out of range, illegal size codes; memory untouched.
    acc2("lh13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1);
    acc2("sw22", 1'b0, 1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
    acc2("lw20b", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hBEEF8000, 1'b0);
    acc2("lw400", 1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1);
    acc2("ld011", 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    acc2("st100", 1'b0, 1'b1, 32'h10, 32'h11111111, 3'b100, 32'h0, 1'b1);
    acc2("lw10b", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // MMIO debug register.
    acc2("swmmio", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, 3'b010, 32'h0, 1'b0);
    chk("dbg_set", b2.debugOut, 32'h12345678);
    acc2("lwmmio", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010, 32'h12345678, 1'b0);
    acc2("sbmmio", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h55, 3'b000, 32'h0, 1'b1);
    chk("dbg_keep", b2.debugOut, 32'h12345678);

    // Read and write together behave as a store.
    acc2("rdwr40", 1'b1, 1'b1, 32'h40, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    acc2("lw40", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    // Reset during WAIT aborts the store.
    acc2("sw30", 1'b0, 1'b1, 32'h30, 32'h11223344, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    drive2(1'b0, 1'b1, 32'h30, 32'hAAAA5555, 3'b010);
    @(negedge clk);
    chk("mid_stall_wait", 32'(b2.stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_stall_rst", 32'(b2.stall), 32'd0);
    chk("mid_rd_rst", b2.readData, 32'h0);
    chk("mid_fault_rst", 32'(b2.fault), 32'd0);
    chk("mid_dbg_rst", b2.debugOut, 32'h0);
    @(negedge clk);
    drive2(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    reset = 1'b0;
    acc2("lw30", 1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 32'h11223344, 1'b0);

    // Combinational build: consecutive store/load cycles, no stall.
    @(negedge clk);
    drive0(1'b0, 1'b1, 32'h50, 32'h13579BDF, 3'b010);
    #1;
    chk("c_sw_stall", 32'(b0.stall), 32'd0);
    chk("c_sw_rd", b0.readData, 32'h0);
    chk("c_sw_fault", 32'(b0.fault), 32'd0);
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h50, 32'h0, 3'b010);
    #1;
    chk("c_lw_stall", 32'(b0.stall), 32'd0);
    chk("c_lw_rd", b0.readData, 32'h13579BDF);
    @(negedge clk);
    drive0(1'b0, 1'b1, 32'h51, 32'hA5, 3'b000);
    #1;
    chk("c_sb_stall", 32'(b0.stall), 32'd0);
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h50, 32'h0, 3'b010);
    #1;
    chk("c_lw2_rd", b0.readData, 32'h1357A5DF);
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h51, 32'h0, 3'b000);
    #1;
    chk("c_lb_rd", b0.readData, 32'hFFFFFFA5);
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h51, 32'h0, 3'b001);
    #1;
    chk("c_lh_fault", 32'(b0.fault), 32'd1);
    chk("c_lh_rd", b0.readData, 32'h0);
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("c_idle_fault", 32'(b0.fault), 32'd0);
    chk("c_idle_rd", b0.readData, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the pipeline's data memory port. It accepts load/store requests (memRead, memWrite, address, writeData, funct3) and serves them from an internal word-addressed RAM with configurable latency. While a request is in service it holds the pipeline with stall. It supports byte, halfword and word accesses, and a memory-mapped debug register.

Parameters:
DEPTH_WORDS, 256, RAM size in 32-bit words; word index = address[31:2]
LATENCY, 2, cycles from request capture to response (0..15)
MMIO_ADDR, 32'hFFFF_FFFC, word address of the debug register

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
memRead  input  1  load request
memWrite  input  1  store request; wins over memRead if both are high
address  input  32  byte address
writeData  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
funct3  input  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu
readData  output  32  load result, extended per funct3
stall  output  1  pipeline hold request
fault  output  1  one-cycle pulse: misaligned, illegal funct3 or out-of-range access
debugOut  output  32  current value of the MMIO debug register

Behaviour:
- Reset (async, immediate): state=IDLE, readData=0, fault=0, debugOut=0, stall=0, counter=0. RAM contents are not reset.
- Reset mid-operation aborts the request. No RAM/MMIO write is committed.
- A request is req = memRead|memWrite. The requester holds all inputs stable while stall=1.
- FSM states: IDLE, WAIT, DONE. LATENCY >= 1:
  - IDLE & req: capture address/data/funct3/type. Counter := LATENCY-1. Next state is DONE if LATENCY==1, else WAIT.
  - WAIT: counter decrements each cycle. At counter==1, next state is DONE.
  - DONE: always returns to IDLE next cycle.
  - A new request seen in IDLE the cycle after DONE is a new access, so back-to-back accesses cost LATENCY+1 cycles each.
- stall = (state==IDLE & req) | (state==WAIT), combinational. stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Load: read data is registered on the edge entering DONE. readData is valid only in DONE and is 0 in all other states.
- Store: commits on the edge leaving DONE (the pipeline-advance edge), and only if there was no fault. Byte lanes:
  - sb writes lane address[1:0].
  - sh writes lanes {address[1],0}+{0,1}.
  - sw writes all lanes.
  - Other lanes are unchanged.
- Load extension:
  - lb/lh sign-extend the selected lane(s).
  - lbu/lhu zero-extend.
  - lw returns the raw word.
- Fault conditions are evaluated on the captured request:
  - funct3 is 011/110/111, or 100/101 on a store;
  - h/hu with address[0]=1;
  - w with address[1:0]!=0;
  - word index >= DEPTH_WORDS and address != MMIO_ADDR.
- On fault: fault=1 in DONE only, readData=0, no write.
- MMIO: address==MMIO_ADDR with funct3=010 only; other sizes at this address fault.
  - sw sets debugOut := writeData on the edge leaving DONE.
  - lw returns debugOut.
  - The RAM is not touched.
- LATENCY==0 (combinational mode): FSM stays in IDLE and stall is always 0.
  - readData is driven combinationally from the RAM during a read request, else 0.
  - Stores commit on the current edge.
  - fault is combinational while the request is present.
- Simultaneous memRead & memWrite: treated as a store. readData=0.
- Counter is 4 bits, so LATENCY > 15 is illegal; the implementation must have an elaboration check.

Test Plan:
- LATENCY=2: sw 32'hDEADBEEF to 0x10, then lw 0x10 → stall high for 2 cycles per access, readData=32'hDEADBEEF in DONE only, 0 otherwise.
- sb 8'h80 to 0x21 over a word preset to 0 → lb 0x21 gives 32'hFFFFFF80, lbu 0x21 gives 32'h00000080, lw 0x20 gives 32'h00008000.
- lh 0x13 and sw 0x22 → fault=1 for one cycle in DONE, readData=0, RAM word unchanged (checked by a later lw).
- sw 32'h12345678 to MMIO_ADDR → debugOut=32'h12345678 after DONE; lw MMIO_ADDR returns it; sb MMIO_ADDR faults and debugOut is unchanged.
- Assert reset during WAIT of sw 0x30 ← 32'hAAAA5555 → stall and readData drop to 0 immediately, state=IDLE; a later lw 0x30 returns the prior contents.
- LATENCY=0 build: lw after sw in consecutive cycles → stall never asserted, readData equals the stored value combinationally.
